// File: rtl/ps2_mouse_tracker.sv
// rtl/ps2_mouse_tracker.sv - PS/2 mouse init handshake, stream packet decoder and clamped cursor tracker
module ps2_mouse_tracker #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int COORD_W        = 10,
  parameter int INIT_X         = 100,
  parameter int INIT_Y         = 100,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRIES    = 3,
  parameter int SKIP_INIT      = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_done_tick,
  input  logic [7:0]         i_rx_dout,
  input  logic               i_tx_done_tick,
  input  logic               i_tx_idle,
  output logic               o_wr_ps2,
  output logic [7:0]         o_tx_din,
  output logic [COORD_W-1:0] o_cursor_x,
  output logic [COORD_W-1:0] o_cursor_y,
  output logic [2:0]         o_buttons,
  output logic               o_pkt_valid,
  output logic               o_init_done,
  output logic               o_init_fail,
  output logic [7:0]         o_sync_err_count
);
  localparam int CW2 = COORD_W + 2;
  localparam logic signed [CW2-1:0] MAX_X = CW2'(SCREEN_W - 1);
  localparam logic signed [CW2-1:0] MAX_Y = CW2'(SCREEN_H - 1);
  localparam logic [31:0] TIMEOUT   = 32'(TIMEOUT_CYCLES);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_WR_FF, S_WAIT_FF, S_ACK1, S_BAT, S_ID, S_WR_F4, S_WAIT_F4, S_ACK2,
    S_PKT0, S_PKT1, S_PKT2, S_UPDATE, S_FAIL
  } state_t;

  state_t             r_state, w_next, w_exp_next;
  logic [31:0]        r_timer;
  logic [7:0]         r_retry;
  logic               r_wr_ps2;
  logic [7:0]         r_tx_din;
  logic [COORD_W-1:0] r_x, r_y;
  logic [2:0]         r_buttons, r_btn_byte;
  logic               r_pkt_valid, r_init_done, r_init_fail;
  logic [7:0]         r_sync_err;
  logic [1:0]         r_ovf, r_sign;
  logic [7:0]         r_b1, r_b2;

  logic               w_timeout, w_wr_req, w_fail, w_err_inc, w_ld0, w_ld1, w_ld2;
  logic [7:0]         w_exp_byte;

  assign w_timeout = (r_timer == TIMEOUT);

  always_comb begin
    w_exp_byte = 8'h00;
    w_exp_next = S_PKT0;
    case (r_state)
      S_ACK1:  begin w_exp_byte = 8'hFA; w_exp_next = S_BAT;   end
      S_BAT:   begin w_exp_byte = 8'hAA; w_exp_next = S_ID;    end
      S_ID:    begin w_exp_byte = 8'h00; w_exp_next = S_WR_F4; end
      S_ACK2:  begin w_exp_byte = 8'hFA; w_exp_next = S_PKT0;  end
      default: ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_wr_req  = 1'b0;
    w_fail    = 1'b0;
    w_err_inc = 1'b0;
    w_ld0     = 1'b0;
    w_ld1     = 1'b0;
    w_ld2     = 1'b0;
    case (r_state)
      S_WR_FF: if (i_tx_idle) begin w_wr_req = 1'b1; w_next = S_WAIT_FF; end
      S_WR_F4: if (i_tx_idle) begin w_wr_req = 1'b1; w_next = S_WAIT_F4; end
      S_WAIT_FF: if (i_tx_done_tick) w_next = S_ACK1; else if (w_timeout) w_fail = 1'b1;
      S_WAIT_F4: if (i_tx_done_tick) w_next = S_ACK2; else if (w_timeout) w_fail = 1'b1;
      S_ACK1, S_BAT, S_ID, S_ACK2: begin
        if (i_rx_done_tick) begin
          if (i_rx_dout == w_exp_byte) w_next = w_exp_next;
          else w_fail = 1'b1;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
      end
      S_PKT0: begin
        if (i_rx_done_tick) begin
          if (i_rx_dout[3]) begin w_ld0 = 1'b1; w_next = S_PKT1; end
          else w_err_inc = 1'b1;
        end
      end
      // Byte beats timeout when both land in the same cycle.
      S_PKT1: begin
        if (i_rx_done_tick) begin w_ld1 = 1'b1; w_next = S_PKT2; end
        else if (w_timeout) begin w_err_inc = 1'b1; w_next = S_PKT0; end
      end
      S_PKT2: begin
        if (i_rx_done_tick) begin w_ld2 = 1'b1; w_next = S_UPDATE; end
        else if (w_timeout) begin w_err_inc = 1'b1; w_next = S_PKT0; end
      end
      S_UPDATE: begin
        w_next    = S_PKT0;
        w_err_inc = i_rx_done_tick;
      end
      default: w_next = r_state;
    endcase
    if (w_fail) w_next = (r_retry < RETRY_MAX) ? S_WR_FF : S_FAIL;
  end

  logic signed [8:0]     w_dx9, w_dy9;
  logic signed [CW2-1:0] w_dx, w_dy, w_new_x, w_new_y;
  logic [COORD_W-1:0]    w_cx, w_cy;

  assign w_dx9   = r_ovf[0] ? 9'sd0 : $signed({r_sign[0], r_b1});
  assign w_dy9   = r_ovf[1] ? 9'sd0 : $signed({r_sign[1], r_b2});
  assign w_dx    = {{(CW2-9){w_dx9[8]}}, w_dx9};
  assign w_dy    = {{(CW2-9){w_dy9[8]}}, w_dy9};
  assign w_new_x = $signed({2'b00, r_x}) + w_dx;
  assign w_new_y = $signed({2'b00, r_y}) - w_dy;
  assign w_cx    = w_new_x[CW2-1] ? '0 : (w_new_x > MAX_X) ? COORD_W'(SCREEN_W - 1) : w_new_x[COORD_W-1:0];
  assign w_cy    = w_new_y[CW2-1] ? '0 : (w_new_y > MAX_Y) ? COORD_W'(SCREEN_H - 1) : w_new_y[COORD_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= (SKIP_INIT != 0) ? S_PKT0 : S_WR_FF;
      r_timer     <= '0;
      r_retry     <= '0;
      r_wr_ps2    <= 1'b0;
      r_tx_din    <= 8'h00;
      r_x         <= COORD_W'(INIT_X);
      r_y         <= COORD_W'(INIT_Y);
      r_buttons   <= 3'b000;
      r_btn_byte  <= 3'b000;
      r_pkt_valid <= 1'b0;
      r_init_done <= (SKIP_INIT != 0);
      r_init_fail <= 1'b0;
      r_sync_err  <= 8'h00;
      r_ovf       <= 2'b00;
      r_sign      <= 2'b00;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_timer <= '0;
      else if (!w_timeout)   r_timer <= r_timer + 32'd1;
      r_wr_ps2 <= w_wr_req;
      r_tx_din <= (w_next == S_WAIT_FF) ? 8'hFF : (w_next == S_WAIT_F4) ? 8'hF4 : 8'h00;
      if (w_fail && (r_retry < RETRY_MAX)) r_retry <= r_retry + 8'd1;
      if (w_next == S_FAIL) r_init_fail <= 1'b1;
      if ((r_state == S_ACK2) && (w_next == S_PKT0)) r_init_done <= 1'b1;
      if (w_err_inc && (r_sync_err != 8'hFF)) r_sync_err <= r_sync_err + 8'd1;
      if (w_ld0) begin
        r_ovf      <= i_rx_dout[7:6];
        r_sign     <= i_rx_dout[5:4];
        r_btn_byte <= i_rx_dout[2:0];
      end
      if (w_ld1) r_b1 <= i_rx_dout;
      if (w_ld2) r_b2 <= i_rx_dout;
      r_pkt_valid <= (r_state == S_UPDATE);
      if (r_state == S_UPDATE) begin
        r_x       <= w_cx;
        r_y       <= w_cy;
        r_buttons <= r_btn_byte;
      end
    end
  end

  assign o_wr_ps2         = r_wr_ps2;
  assign o_tx_din         = r_tx_din;
  assign o_cursor_x       = r_x;
  assign o_cursor_y       = r_y;
  assign o_buttons        = r_buttons;
  assign o_pkt_valid      = r_pkt_valid;
  assign o_init_done      = r_init_done;
  assign o_init_fail      = r_init_fail;
  assign o_sync_err_count = r_sync_err;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb/tb_ps2_mouse_tracker.sv - directed bench for ps2_mouse_tracker (init DUT and skip-init packet DUT)
module tb_ps2_mouse_tracker;
  localparam int TO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       a_rst, a_rx_tick, a_tx_done, a_tx_idle, a_wr, a_pv, a_done, a_fail;
  logic [7:0] a_rx_dout, a_tx_din, a_serr;
  logic [9:0] a_cx, a_cy;
  logic [2:0] a_btn;

  logic       b_rst, b_rx_tick, b_tx_done, b_tx_idle, b_wr, b_pv, b_done, b_fail;
  logic [7:0] b_rx_dout, b_tx_din, b_serr;
  logic [9:0] b_cx, b_cy;
  logic [2:0] b_btn;

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(3), .SKIP_INIT(0)) u_init (
    .i_clk(clk), .i_rst(a_rst), .i_rx_done_tick(a_rx_tick), .i_rx_dout(a_rx_dout),
    .i_tx_done_tick(a_tx_done), .i_tx_idle(a_tx_idle), .o_wr_ps2(a_wr), .o_tx_din(a_tx_din),
    .o_cursor_x(a_cx), .o_cursor_y(a_cy), .o_buttons(a_btn), .o_pkt_valid(a_pv),
    .o_init_done(a_done), .o_init_fail(a_fail), .o_sync_err_count(a_serr));

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(3), .SKIP_INIT(1)) u_pkt (
    .i_clk(clk), .i_rst(b_rst), .i_rx_done_tick(b_rx_tick), .i_rx_dout(b_rx_dout),
    .i_tx_done_tick(b_tx_done), .i_tx_idle(b_tx_idle), .o_wr_ps2(b_wr), .o_tx_din(b_tx_din),
    .o_cursor_x(b_cx), .o_cursor_y(b_cy), .o_buttons(b_btn), .o_pkt_valid(b_pv),
    .o_init_done(b_done), .o_init_fail(b_fail), .o_sync_err_count(b_serr));

  int a_wr_cnt = 0;
  always @(negedge clk) if (a_wr) a_wr_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic a_send(input logic [7:0] b);
    @(negedge clk); a_rx_dout = b; a_rx_tick = 1'b1;
    @(negedge clk); a_rx_tick = 1'b0;
  endtask

  task automatic a_txdone();
    @(negedge clk); a_tx_done = 1'b1;
    @(negedge clk); a_tx_done = 1'b0;
  endtask

  task automatic a_wait_wr(input int exp_din, input string tag);
    int got = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_wr) begin got = int'(a_tx_din); break; end
    end
    check(tag, got, exp_din);
  endtask

  task automatic b_send(input logic [7:0] b);
    @(negedge clk); b_rx_dout = b; b_rx_tick = 1'b1;
    @(negedge clk); b_rx_tick = 1'b0;
  endtask

  task automatic b_reset();
    @(negedge clk); b_rst = 1'b1;
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
  endtask

  task automatic b_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input int ex, input int ey, input int ebtn, input string tag);
    b_send(b0);
    b_send(b1);
    @(negedge clk); b_rx_dout = b2; b_rx_tick = 1'b1;
    @(negedge clk); b_rx_tick = 1'b0;
    check({tag, ".pv_early"}, int'(b_pv), 0);
    @(negedge clk);
    check({tag, ".pv"}, int'(b_pv), 1);
    check({tag, ".x"}, int'(b_cx), ex);
    check({tag, ".y"}, int'(b_cy), ey);
    check({tag, ".btn"}, int'(b_btn), ebtn);
    @(negedge clk);
    check({tag, ".pv_after"}, int'(b_pv), 0);
  endtask

  initial begin
    int base;
    a_rst = 1'b1; a_rx_tick = 1'b0; a_rx_dout = 8'h00; a_tx_done = 1'b0; a_tx_idle = 1'b1;
    b_rst = 1'b1; b_rx_tick = 1'b0; b_rx_dout = 8'h00; b_tx_done = 1'b0; b_tx_idle = 1'b1;
    repeat (3) @(negedge clk);

    check("init.rst_done", int'(a_done), 0);
    check("init.rst_fail", int'(a_fail), 0);
    check("init.rst_wr", int'(a_wr), 0);
    base = a_wr_cnt;
    a_rst = 1'b0;
    a_wait_wr(8'hFF, "init.wr_ff");
    a_txdone();
    a_send(8'hFA);
    a_send(8'hAA);
    a_send(8'h00);
    a_wait_wr(8'hF4, "init.wr_f4");
    a_txdone();
    check("init.done_early", int'(a_done), 0);
    a_send(8'hFA);
    check("init.done", int'(a_done), 1);
    check("init.x", int'(a_cx), 100);
    check("init.y", int'(a_cy), 100);
    check("init.wr_count", a_wr_cnt - base, 2);

    @(negedge clk); a_rst = 1'b1;
    repeat (2) @(negedge clk);
    base = a_wr_cnt;
    a_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_wait_wr(8'hFF, "retry.wr_ff");
      a_txdone();
      a_send(8'hFA);
      a_send(8'hFC);
    end
    repeat (3 * TO) @(negedge clk);
    check("retry.wr_count", a_wr_cnt - base, 4);
    check("retry.fail", int'(a_fail), 1);
    check("retry.done", int'(a_done), 0);

    b_reset();
    check("pkt.rst_x", int'(b_cx), 100);
    check("pkt.rst_y", int'(b_cy), 100);
    check("pkt.rst_btn", int'(b_btn), 0);
    check("pkt.rst_pv", int'(b_pv), 0);
    check("pkt.rst_done", int'(b_done), 1);
    check("pkt.rst_serr", int'(b_serr), 0);
    check("pkt.rst_txdin", int'(b_tx_din), 0);
    b_pkt(8'h08, 8'h05, 8'h03, 105, 97, 0, "p_basic");

    b_reset();
    b_pkt(8'h38, 8'hF0, 8'hF0, 84, 116, 0, "p_neg");

    b_reset();
    b_pkt(8'h1F, 8'h00, 8'h00, 0, 100, 7, "clamp_lo");
    b_pkt(8'h08, 8'hFF, 8'h00, 255, 100, 0, "ramp1");
    b_pkt(8'h08, 8'hFF, 8'h00, 510, 100, 0, "ramp2");
    b_pkt(8'h08, 8'hFF, 8'h00, 639, 100, 0, "ramp3");

    b_reset();
    b_send(8'h00);
    check("sync.drop", int'(b_serr), 1);
    b_pkt(8'h48, 8'hFF, 8'h00, 100, 100, 0, "ovf");
    b_send(8'h08);
    repeat (TO + 10) @(negedge clk);
    check("sync.timeout", int'(b_serr), 2);
    b_pkt(8'h08, 8'h05, 8'h03, 105, 97, 0, "resync");
    check("sync.no_extra", int'(b_serr), 2);

    b_send(8'h08);
    b_send(8'h05);
    @(negedge clk); b_rx_dout = 8'h03; b_rx_tick = 1'b1;
    @(negedge clk); b_rx_dout = 8'h08;
    @(negedge clk); b_rx_tick = 1'b0;
    check("upd_drop.pv", int'(b_pv), 1);
    check("upd_drop.x", int'(b_cx), 110);
    check("upd_drop.y", int'(b_cy), 94);
    check("upd_drop.serr", int'(b_serr), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
